// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared dmem/MMIO slave port.
// Grants are combinational; a master may hold the port under lock for up to MAX_LOCK cycles.
module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_a,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic [DW-1:0] m0_rd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rd,
  output logic          s_we,
  output logic [AW-1:0] s_a,
  output logic [DW-1:0] s_wd,
  input  logic [DW-1:0] s_rd
);
  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;

  logic          prio;
  owner_t        owner;
  logic [CW-1:0] lock_cnt;
  logic          g0, g1, lk;
  logic [CW:0]   cnt_inc;

  // Owner keeps the port while it requests; otherwise plain round-robin.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (owner == OWN0 && m0_req)      g0 = 1'b1;
      else if (owner == OWN1 && m1_req) g1 = 1'b1;
      else if (m0_req && m1_req) begin
        g0 = ~prio;
        g1 = prio;
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  assign lk      = g0 ? m0_lock : m1_lock;
  assign cnt_inc = {1'b0, lock_cnt} + 1'b1;

  assign m0_gnt   = g0;
  assign m1_gnt   = g1;
  assign m0_stall = m0_req & ~g0;
  assign s_a      = g1 ? m1_a  : m0_a;
  assign s_wd     = g1 ? m1_wd : m0_wd;
  assign s_we     = (g0 & m0_we) | (g1 & m1_we);
  assign m0_rd    = s_rd;
  assign m1_rd    = s_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      owner    <= NONE;
      lock_cnt <= '0;
    end else if (g0 || g1) begin
      prio <= g0;
      // Ownership ends once the lock limit is reached, so prio hands over to the competitor.
      if (lk && cnt_inc < (CW+1)'(MAX_LOCK)) begin
        owner    <= g0 ? OWN0 : OWN1;
        lock_cnt <= cnt_inc[CW-1:0];
      end else begin
        owner    <= NONE;
        lock_cnt <= '0;
      end
    end else begin
      owner    <= NONE;
      lock_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, then random traffic against a reference model.
module tb_dmem_arbiter;
  localparam int DW = 32, AW = 32, MAXL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_a, m1_a;
  logic [DW-1:0] m0_wd, m1_wd;
  logic          m0_gnt, m0_stall, m1_gnt, s_we;
  logic [DW-1:0] m0_rd, m1_rd, s_wd, s_rd;
  logic [AW-1:0] s_a;

  dmem_arbiter #(.DW(DW), .AW(AW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_a(m0_a), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_a(m1_a), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rd(m1_rd),
    .s_we(s_we), .s_a(s_a), .s_wd(s_wd), .s_rd(s_rd)
  );

  // Slave: 16-word memory, combinational read, synchronous write.
  logic [31:0] mem [16];
  logic        mem_clr;
  assign s_rd = mem[s_a[5:2]];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (s_we) mem[s_a[5:2]] <= s_wd;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, r0, l0, w0;
    logic [31:0] a0, wd0;
    logic        r1, l1, w1;
    logic [31:0] a1, wd1;
    logic        eg0, eg1, eswe, chk_rd;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rs, r0, l0, w0, input logic [31:0] a0, wd0,
                     input logic r1, l1, w1, input logic [31:0] a1, wd1,
                     input logic eg0, eg1, eswe, crd, input logic [31:0] erd);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.wd0 = wd0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.wd1 = wd1;
    v.eg0 = eg0; v.eg1 = eg1; v.eswe = eswe; v.chk_rd = crd; v.erd = erd;
    vecs.push_back(v);
  endtask

  // Reference model state
  int          prio_m, own_m, cnt_m;
  logic [31:0] exp_mem [16];

  initial begin
    logic        r0, r1, l0, l1, w0, w1, rs, eg0, eg1, pend1;
    logic [31:0] a0, a1, d0, d1, ea, erd;

    rst = 1'b1; mem_clr = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_a = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_a = 0; m1_wd = 0;
    @(posedge clk); #1 mem_clr = 1'b0;

    // reset with both requesting (and writing): nothing granted
    add(1,1,0,1,32'h10,32'h1, 1,0,1,32'h20,32'h2, 0,0,0,0,0);
    add(1,1,0,1,32'h10,32'h1, 1,0,1,32'h20,32'h2, 0,0,0,0,0);
    add(0,1,0,0,32'h10,0, 0,0,0,32'h20,0, 1,0,0,0,0);   // prio -> 1
    add(0,0,0,0,32'h10,0, 0,0,0,32'h20,0, 0,0,0,0,0);   // idle
    // round-robin contention
    add(0,1,0,0,32'h10,0, 1,0,0,32'h20,0, 0,1,0,0,0);
    add(0,1,0,0,32'h10,0, 1,0,0,32'h20,0, 1,0,0,0,0);
    add(0,1,0,0,32'h10,0, 1,0,0,32'h20,0, 0,1,0,0,0);
    add(0,1,0,0,32'h10,0, 1,0,0,32'h20,0, 1,0,0,0,0);
    // write steering then read-back by M0
    add(0,0,0,0,32'h10,0, 1,0,1,32'h04,32'hDEADBEEF, 0,1,1,0,0);
    add(0,1,0,0,32'h04,0, 0,0,0,32'h20,0, 1,0,0,1,32'hDEADBEEF);
    // M1 lock: 8 cycles then forced release to M0
    for (int i = 0; i < MAXL; i++)
      add(0,1,0,0,32'h10,0, 1,1,0,32'h20,0, 0,1,0,0,0);
    add(0,1,0,0,32'h10,0, 1,1,0,32'h20,0, 1,0,0,0,0);   // prio -> 1
    // M0 locks 3 cycles with M1 pending, then drops req+lock
    add(0,1,1,0,32'h10,0, 0,0,0,32'h20,0, 1,0,0,0,0);
    add(0,1,1,0,32'h10,0, 1,0,0,32'h20,0, 1,0,0,0,0);
    add(0,1,1,0,32'h10,0, 1,0,0,32'h20,0, 1,0,0,0,0);
    add(0,0,0,0,32'h10,0, 1,0,0,32'h20,0, 0,1,0,0,0);   // prio -> 0
    // M1 locks to cnt 4, reset pulse, then M0 wins on prio=0
    for (int i = 0; i < 4; i++)
      add(0,0,0,0,32'h10,0, 1,1,0,32'h20,0, 0,1,0,0,0);
    add(1,1,0,1,32'h10,32'h5, 1,1,1,32'h20,32'h6, 0,0,0,0,0);
    add(0,1,0,0,32'h10,0, 1,1,0,32'h20,0, 1,0,0,0,0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      m0_req = vecs[i].r0; m0_lock = vecs[i].l0; m0_we = vecs[i].w0;
      m0_a = vecs[i].a0; m0_wd = vecs[i].wd0;
      m1_req = vecs[i].r1; m1_lock = vecs[i].l1; m1_we = vecs[i].w1;
      m1_a = vecs[i].a1; m1_wd = vecs[i].wd1;
      #3;
      chk($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(vecs[i].eg0));
      chk($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(vecs[i].eg1));
      chk($sformatf("v%0d m0_stall", i), 32'(m0_stall), 32'(vecs[i].r0 & ~vecs[i].eg0));
      chk($sformatf("v%0d s_we", i), 32'(s_we), 32'(vecs[i].eswe));
      chk($sformatf("v%0d s_a", i), s_a, vecs[i].eg1 ? vecs[i].a1 : vecs[i].a0);
      chk($sformatf("v%0d s_wd", i), s_wd, vecs[i].eg1 ? vecs[i].wd1 : vecs[i].wd0);
      if (vecs[i].chk_rd) chk($sformatf("v%0d m0_rd", i), m0_rd, vecs[i].erd);
      @(posedge clk); #1;
    end

    // Random phase: model starts from reset; memory mirror from a clean slate.
    rst = 1'b1; mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    prio_m = 0; own_m = -1; cnt_m = 0;
    pend1 = 1'b0;
    r1 = 0; l1 = 0; w1 = 0; a1 = 0; d1 = 0;

    for (int c = 0; c < 600; c++) begin
      rs = ($urandom_range(0, 40) == 0);
      r0 = $urandom_range(0, 1) == 1; l0 = $urandom_range(0, 2) != 0;
      w0 = $urandom_range(0, 1) == 1;
      a0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; d0 = $urandom;
      if (!pend1) begin  // master 1 holds its request until granted
        r1 = $urandom_range(0, 1) == 1; l1 = $urandom_range(0, 2) != 0;
        w1 = $urandom_range(0, 1) == 1;
        a1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; d1 = $urandom;
      end else l1 = $urandom_range(0, 2) != 0;

      eg0 = 0; eg1 = 0;
      if (!rs) begin
        if (own_m == 0 && r0)      eg0 = 1;
        else if (own_m == 1 && r1) eg1 = 1;
        else if (r0 && r1)         begin eg0 = (prio_m == 0); eg1 = (prio_m == 1); end
        else                       begin eg0 = r0; eg1 = r1; end
      end
      ea  = eg1 ? a1 : a0;
      erd = exp_mem[ea[5:2]];

      rst = rs;
      m0_req = r0; m0_lock = l0; m0_we = w0; m0_a = a0; m0_wd = d0;
      m1_req = r1; m1_lock = l1; m1_we = w1; m1_a = a1; m1_wd = d1;
      #3;
      chk("r m0_gnt", 32'(m0_gnt), 32'(eg0));
      chk("r m1_gnt", 32'(m1_gnt), 32'(eg1));
      chk("r m0_stall", 32'(m0_stall), 32'(r0 & ~eg0));
      chk("r s_we", 32'(s_we), 32'((eg0 & w0) | (eg1 & w1)));
      chk("r s_a", s_a, ea);
      chk("r s_wd", s_wd, eg1 ? d1 : d0);
      chk("r m0_rd", m0_rd, erd);
      chk("r m1_rd", m1_rd, erd);

      if (rs) begin
        prio_m = 0; own_m = -1; cnt_m = 0;
      end else if (eg0 || eg1) begin
        int x;
        x = eg1 ? 1 : 0;
        if ((x == 0 && w0) || (x == 1 && w1)) exp_mem[ea[5:2]] = eg1 ? d1 : d0;
        prio_m = 1 - x;
        if (((x == 0) ? l0 : l1) && cnt_m + 1 < MAXL) begin own_m = x; cnt_m = cnt_m + 1; end
        else begin own_m = -1; cnt_m = 0; end
      end else begin
        own_m = -1; cnt_m = 0;
      end
      pend1 = r1 & ~eg1;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
